gvp_vector_loader: RTL and testbench

Upstream feeder for the GVP vector program port. It takes a 32-bit AXI-Stream of vector program words from the PS/DMA side and assembles each 16-word frame into the 512-bit vp_set block. It validates each frame, then issues a timed setvec strobe. Programming is only allowed while the GVP is held in reset.

---
 rtl/gvp_pkg.sv | 46 ++++
 rtl/gvp_vector_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_gvp_vector_loader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gvp_pkg.sv
// -----------------------------------------------------------------------------
// gvp_pkg
// Shared definitions for the GVP vector program loader.
//   - GVP_VEC_WORDS / GVP_VEC_BITS : frame geometry (16 x 32-bit words)
//   - word index constants          : position of each field inside a frame
//   - gvp_state_e                   : loader FSM states
//   - sat_inc16                     : saturating 16-bit increment
// -----------------------------------------------------------------------------
package gvp_pkg;

    localparam int GVP_VEC_WORDS = 16;
    localparam int GVP_VEC_BITS  = 512;

    // Word positions inside a vector program frame
    localparam int VADR    = 0;
    localparam int N       = 1;
    localparam int NII     = 2;
    localparam int OPTIONS = 3;
    localparam int NREP    = 4;
    localparam int NEXT    = 5;
    localparam int DX      = 6;
    localparam int DY      = 7;
    localparam int DZ      = 8;
    localparam int DU      = 9;
    localparam int DECII   = 15;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        DRAIN   = 3'd1,
        CHECK   = 3'd2,
        STROBE  = 3'd3,
        GAP     = 3'd4
    } gvp_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gvp_vector_loader.sv
// -----------------------------------------------------------------------------
// gvp_vector_loader
// Collects 16-word frames from a 32-bit AXI-Stream into a shadow register,
// validates the vector address, then publishes the frame on vp_set and raises
// setvec for SETVEC_CYCLES, followed by a GAP_CYCLES quiet period.
// Programming is only permitted while gvp_reset is high.
//
// Ports:
//   a_clk, aresetn          clock, asynchronous active-low reset
//   S_AXIS_tdata/tvalid/    program word stream (tlast marks word 15)
//   tlast/tready
//   gvp_reset               1 = GVP held, loading allowed
//   clear_status            pulse: clears sticky errors and load_count
//   vp_set                  last valid 512-bit vector (word k at [32k+31:32k])
//   setvec                  program strobe
//   busy                    frame partially collected or strobe/gap running
//   load_count              saturating count of programmed frames
//   err_frame/addr/abort    sticky error flags
// -----------------------------------------------------------------------------
module gvp_vector_loader
    import gvp_pkg::*;
#(
    parameter int unsigned NUM_VECTORS   = 16,
    parameter int unsigned SETVEC_CYCLES = 4,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic                    a_clk,
    input  logic                    aresetn,
    input  logic [31:0]             S_AXIS_tdata,
    input  logic                    S_AXIS_tvalid,
    input  logic                    S_AXIS_tlast,
    output logic                    S_AXIS_tready,
    input  logic                    gvp_reset,
    input  logic                    clear_status,
    output logic [GVP_VEC_BITS-1:0] vp_set,
    output logic                    setvec,
    output logic                    busy,
    output logic [15:0]             load_count,
    output logic                    err_frame,
    output logic                    err_addr,
    output logic                    err_abort
);

    localparam logic [15:0] STROBE_LOAD = 16'(SETVEC_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYCLES - 1);
    localparam logic [3:0]  LAST_IDX    = 4'(GVP_VEC_WORDS - 1);

    logic [GVP_VEC_WORDS-1:0][31:0] r_shadow;
    logic [GVP_VEC_BITS-1:0]        r_vp_set;
    gvp_state_e                     r_state;
    gvp_state_e                     w_state_nxt;
    logic [3:0]                     r_word_idx;
    logic [3:0]                     w_word_idx_nxt;
    logic [15:0]                    r_timer;
    logic [15:0]                    w_timer_nxt;
    logic                           r_setvec;
    logic                           w_setvec_nxt;
    logic                           r_tready;
    logic                           w_tready_nxt;
    logic                           r_busy;
    logic                           w_busy_nxt;
    logic [15:0]                    r_load_count;
    logic                           r_err_frame;
    logic                           r_err_addr;
    logic                           r_err_abort;
    logic                           w_accept;
    logic                           w_vadr_bad;
    logic                           w_set_frame;
    logic                           w_set_addr;
    logic                           w_set_abort;
    logic                           w_load;

    // tready is registered and already qualified by gvp_reset, so a handshake
    // is simply valid & ready.
    assign w_accept   = S_AXIS_tvalid & r_tready;
    assign w_vadr_bad = (r_shadow[VADR] >= 32'(NUM_VECTORS));

    assign S_AXIS_tready = r_tready;
    assign vp_set        = r_vp_set;
    assign setvec        = r_setvec;
    assign busy          = r_busy;
    assign load_count    = r_load_count;
    assign err_frame     = r_err_frame;
    assign err_addr      = r_err_addr;
    assign err_abort     = r_err_abort;

    // Next-state, timer and event decode for the loader FSM
    always_comb begin
        w_state_nxt    = r_state;
        w_word_idx_nxt = r_word_idx;
        w_timer_nxt    = r_timer;
        w_setvec_nxt   = r_setvec;
        w_set_frame    = 1'b0;
        w_set_addr     = 1'b0;
        w_set_abort    = 1'b0;
        w_load         = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_accept) begin
                    if (r_word_idx == LAST_IDX) begin
                        w_word_idx_nxt = 4'd0;
                        if (S_AXIS_tlast) begin
                            w_state_nxt = CHECK;
                        end else begin
                            // Overlong frame: discard the remainder up to tlast
                            w_set_frame = 1'b1;
                            w_state_nxt = DRAIN;
                        end
                    end else if (S_AXIS_tlast) begin
                        // Short frame: drop what was collected and restart
                        w_set_frame    = 1'b1;
                        w_word_idx_nxt = 4'd0;
                    end else begin
                        w_word_idx_nxt = r_word_idx + 4'd1;
                    end
                end else begin
                    w_word_idx_nxt = r_word_idx;
                end
            end
            DRAIN: begin
                if (w_accept && S_AXIS_tlast) begin
                    w_state_nxt    = COLLECT;
                    w_word_idx_nxt = 4'd0;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            CHECK: begin
                if (w_vadr_bad) begin
                    w_set_addr  = 1'b1;
                    w_state_nxt = COLLECT;
                end else begin
                    w_load       = 1'b1;
                    w_setvec_nxt = 1'b1;
                    w_timer_nxt  = STROBE_LOAD;
                    w_state_nxt  = STROBE;
                end
            end
            STROBE: begin
                if (!gvp_reset) begin
                    // GVP released mid-strobe: abandon the strobe immediately
                    w_set_abort  = 1'b1;
                    w_setvec_nxt = 1'b0;
                    w_timer_nxt  = GAP_LOAD;
                    w_state_nxt  = GAP;
                end else if (r_timer == 16'd0) begin
                    w_setvec_nxt = 1'b0;
                    w_timer_nxt  = GAP_LOAD;
                    w_state_nxt  = GAP;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            GAP: begin
                if (r_timer == 16'd0) begin
                    w_state_nxt    = COLLECT;
                    w_word_idx_nxt = 4'd0;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            default: begin
                w_state_nxt    = COLLECT;
                w_word_idx_nxt = 4'd0;
                w_setvec_nxt   = 1'b0;
            end
        endcase
        w_tready_nxt = gvp_reset & ((w_state_nxt == COLLECT) | (w_state_nxt == DRAIN));
        w_busy_nxt   = (w_word_idx_nxt != 4'd0) | (w_state_nxt != COLLECT);
    end

    // State, shadow frame, published vector and status registers
    always_ff @(posedge a_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= COLLECT;
            r_word_idx   <= 4'd0;
            r_timer      <= 16'd0;
            r_shadow     <= '0;
            r_vp_set     <= '0;
            r_setvec     <= 1'b0;
            r_tready     <= 1'b0;
            r_busy       <= 1'b0;
            r_load_count <= 16'd0;
            r_err_frame  <= 1'b0;
            r_err_addr   <= 1'b0;
            r_err_abort  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_idx <= w_word_idx_nxt;
            r_timer    <= w_timer_nxt;
            r_setvec   <= w_setvec_nxt;
            r_tready   <= w_tready_nxt;
            r_busy     <= w_busy_nxt;
            if (w_accept && (r_state == COLLECT)) begin
                r_shadow[r_word_idx] <= S_AXIS_tdata;
            end
            if (w_load) begin
                r_vp_set <= r_shadow;
            end
            // clear_status wins over any same-cycle error or count update
            if (clear_status) begin
                r_load_count <= 16'd0;
                r_err_frame  <= 1'b0;
                r_err_addr   <= 1'b0;
                r_err_abort  <= 1'b0;
            end else begin
                if (w_load) begin
                    r_load_count <= sat_inc16(r_load_count);
                end
                if (w_set_frame) begin
                    r_err_frame <= 1'b1;
                end
                if (w_set_addr) begin
                    r_err_addr <= 1'b1;
                end
                if (w_set_abort) begin
                    r_err_abort <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gvp_vector_loader.sv
// -----------------------------------------------------------------------------
// tb_gvp_vector_loader
// Directed bench for gvp_vector_loader: frame assembly, strobe timing,
// frame/address/abort errors, gvp_reset pausing, clear_status and async reset.
// -----------------------------------------------------------------------------
module tb_gvp_vector_loader;

    logic          a_clk = 1'b0;
    logic          aresetn;
    logic [31:0]   S_AXIS_tdata;
    logic          S_AXIS_tvalid;
    logic          S_AXIS_tlast;
    logic          S_AXIS_tready;
    logic          gvp_reset;
    logic          clear_status;
    logic [511:0]  vp_set;
    logic          setvec;
    logic          busy;
    logic [15:0]   load_count;
    logic          err_frame;
    logic          err_addr;
    logic          err_abort;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   fr [0:16];
    logic [511:0]  exp_vp;
    int            first_hi;
    int            n_hi;
    int            n_nr;
    int            low_cnt;

    always #5 a_clk = ~a_clk;

    gvp_vector_loader dut (
        .a_clk         (a_clk),
        .aresetn       (aresetn),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tlast  (S_AXIS_tlast),
        .S_AXIS_tready (S_AXIS_tready),
        .gvp_reset     (gvp_reset),
        .clear_status  (clear_status),
        .vp_set        (vp_set),
        .setvec        (setvec),
        .busy          (busy),
        .load_count    (load_count),
        .err_frame     (err_frame),
        .err_addr      (err_addr),
        .err_abort     (err_abort)
    );

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge a_clk);
        #1;
    endtask

    // Present one word and wait (bounded) until it is taken; tvalid stays high
    task automatic send_word(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        S_AXIS_tdata  = d;
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tlast  = last;
        while (!S_AXIS_tready && n < 100) begin
            step();
            n++;
        end
        check_eq("accept_wait", 512'(S_AXIS_tready), 512'(1));
        step();
    endtask

    task automatic send_frame(input int nwords, input logic hold);
        for (int i = 0; i < nwords; i++) begin
            send_word(fr[i], (i == nwords - 1) ? 1'b1 : 1'b0);
        end
        S_AXIS_tlast = 1'b0;
        if (!hold) begin
            S_AXIS_tvalid = 1'b0;
        end
    endtask

    task automatic fill(input logic [31:0] vadr, input logic [31:0] seed);
        fr[0] = vadr;
        for (int k = 1; k < 17; k++) begin
            fr[k] = seed + 32'(k) * 32'h0101_0101;
        end
    endtask

    function automatic logic [511:0] pack_fr();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) begin
            v[32*k +: 32] = fr[k];
        end
        return v;
    endfunction

    // From the current cycle (1 = cycle after last word) until tready returns
    task automatic run_post(output int f_hi, output int c_hi, output int c_nr);
        f_hi = 0;
        c_hi = 0;
        c_nr = 0;
        for (int c = 1; c <= 60; c++) begin
            if (S_AXIS_tready) break;
            if (setvec) begin
                c_hi++;
                if (f_hi == 0) f_hi = c;
            end
            c_nr++;
            step();
        end
        check_eq("post_ready_wait", 512'(S_AXIS_tready), 512'(1));
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
    endtask

    initial begin
        aresetn       = 1'b0;
        gvp_reset     = 1'b0;
        clear_status  = 1'b0;
        S_AXIS_tdata  = 32'd0;
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast  = 1'b0;
        exp_vp        = '0;
        repeat (3) step();
        check_eq("rst_vp_set", vp_set, 512'(0));
        check_eq("rst_setvec", 512'(setvec), 512'(0));
        check_eq("rst_tready", 512'(S_AXIS_tready), 512'(0));
        check_eq("rst_busy", 512'(busy), 512'(0));
        check_eq("rst_count", 512'(load_count), 512'(0));
        check_eq("rst_errs", 512'({err_frame, err_addr, err_abort}), 512'(0));
        aresetn   = 1'b1;
        gvp_reset = 1'b1;
        step();
        check_eq("ready_after_rst", 512'(S_AXIS_tready), 512'(1));

        // Reference frame
        fr[0] = 32'h0;     fr[1] = 32'h100;   fr[2] = 32'h3;   fr[3] = 32'hC0801;
        fr[4] = 32'h0;     fr[5] = 32'h0;     fr[6] = 32'h0;   fr[7] = 32'h0;
        fr[8] = 32'h0;     fr[9] = 32'h0;     fr[10] = 32'hF3A22; fr[11] = 32'h0;
        fr[12] = 32'h0;    fr[13] = 32'h0;    fr[14] = 32'h0;  fr[15] = 32'h4;
        send_frame(16, 1'b0);
        check_eq("t1_busy_check", 512'(busy), 512'(1));
        run_post(first_hi, n_hi, n_nr);
        check_eq("t1_setvec_start", 512'(first_hi), 512'(2));
        check_eq("t1_setvec_len", 512'(n_hi), 512'(4));
        check_eq("t1_notready", 512'(n_nr), 512'(7));
        check_eq("t1_vadr", 512'(vp_set[31:0]), 512'(32'h0));
        check_eq("t1_options", 512'(vp_set[127:96]), 512'(32'hC0801));
        check_eq("t1_decii", 512'(vp_set[511:480]), 512'(32'h4));
        exp_vp = pack_fr();
        check_eq("t1_vp_set", vp_set, exp_vp);
        check_eq("t1_count", 512'(load_count), 512'(1));
        check_eq("t1_busy_idle", 512'(busy), 512'(0));

        // Back-to-back frames with tvalid held between them
        pulse_clear();
        check_eq("clr_count", 512'(load_count), 512'(0));
        for (int v = 0; v < 3; v++) begin
            fill(32'(v), 32'h1000_0000 * 32'(v + 1));
            send_frame(16, (v < 2) ? 1'b1 : 1'b0);
            run_post(first_hi, n_hi, n_nr);
            check_eq("t2_setvec_len", 512'(n_hi), 512'(4));
            check_eq("t2_notready", 512'(n_nr), 512'(7));
        end
        exp_vp = pack_fr();
        check_eq("t2_vp_set", vp_set, exp_vp);
        check_eq("t2_count", 512'(load_count), 512'(3));

        // Short frame (tlast on word 9) then a clean frame
        pulse_clear();
        fill(32'd3, 32'h3000_0000);
        send_frame(10, 1'b0);
        run_post(first_hi, n_hi, n_nr);
        check_eq("t3_short_nostrobe", 512'(n_hi), 512'(0));
        check_eq("t3_err_frame", 512'(err_frame), 512'(1));
        check_eq("t3_busy_idle", 512'(busy), 512'(0));
        fill(32'd5, 32'h5000_0000);
        send_frame(16, 1'b0);
        run_post(first_hi, n_hi, n_nr);
        check_eq("t3_clean_strobe", 512'(n_hi), 512'(4));
        exp_vp = pack_fr();
        check_eq("t3_vp_set", vp_set, exp_vp);
        check_eq("t3_count", 512'(load_count), 512'(1));

        // Overlong frame (tlast on word 16) then a clean frame
        pulse_clear();
        fill(32'd6, 32'h6000_0000);
        send_frame(17, 1'b0);
        run_post(first_hi, n_hi, n_nr);
        check_eq("t4_long_nostrobe", 512'(n_hi), 512'(0));
        check_eq("t4_err_frame", 512'(err_frame), 512'(1));
        check_eq("t4_vp_kept", vp_set, exp_vp);
        check_eq("t4_busy_idle", 512'(busy), 512'(0));
        fill(32'd7, 32'h7000_0000);
        send_frame(16, 1'b0);
        run_post(first_hi, n_hi, n_nr);
        check_eq("t4_clean_strobe", 512'(n_hi), 512'(4));
        exp_vp = pack_fr();
        check_eq("t4_vp_set", vp_set, exp_vp);

        // Out-of-range vector address
        pulse_clear();
        fill(32'd16, 32'h8000_0000);
        send_frame(16, 1'b0);
        run_post(first_hi, n_hi, n_nr);
        check_eq("t5_nostrobe", 512'(n_hi), 512'(0));
        check_eq("t5_notready", 512'(n_nr), 512'(1));
        check_eq("t5_err_addr", 512'(err_addr), 512'(1));
        check_eq("t5_vp_kept", vp_set, exp_vp);
        check_eq("t5_count", 512'(load_count), 512'(0));

        // gvp_reset dropped mid-frame pauses collection
        fill(32'd9, 32'h9000_0000);
        for (int i = 0; i < 8; i++) begin
            send_word(fr[i], 1'b0);
        end
        S_AXIS_tvalid = 1'b0;
        gvp_reset     = 1'b0;
        step();
        low_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!S_AXIS_tready) low_cnt++;
            step();
        end
        check_eq("t6_paused", 512'(low_cnt), 512'(20));
        check_eq("t6_busy", 512'(busy), 512'(1));
        gvp_reset = 1'b1;
        for (int i = 8; i < 16; i++) begin
            send_word(fr[i], (i == 15) ? 1'b1 : 1'b0);
        end
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast  = 1'b0;
        run_post(first_hi, n_hi, n_nr);
        check_eq("t6_setvec_start", 512'(first_hi), 512'(2));
        check_eq("t6_setvec_len", 512'(n_hi), 512'(4));
        exp_vp = pack_fr();
        check_eq("t6_vp_set", vp_set, exp_vp);

        // gvp_reset dropped in the 2nd strobe cycle
        pulse_clear();
        fill(32'd11, 32'hB000_0000);
        send_frame(16, 1'b0);
        step();
        check_eq("t7_strobe_c1", 512'(setvec), 512'(1));
        step();
        check_eq("t7_strobe_c2", 512'(setvec), 512'(1));
        gvp_reset = 1'b0;
        step();
        check_eq("t7_setvec_drop", 512'(setvec), 512'(0));
        check_eq("t7_err_abort", 512'(err_abort), 512'(1));
        check_eq("t7_count", 512'(load_count), 512'(1));
        gvp_reset = 1'b1;
        run_post(first_hi, n_hi, n_nr);
        check_eq("t7_no_restrobe", 512'(n_hi), 512'(0));
        check_eq("t7_gap", 512'(n_nr), 512'(2));
        exp_vp = pack_fr();
        check_eq("t7_vp_set", vp_set, exp_vp);

        // clear_status: plain clear and precedence over a same-cycle error
        fill(32'd1, 32'hC000_0000);
        send_frame(3, 1'b0);
        check_eq("t8_err_frame_set", 512'(err_frame), 512'(1));
        pulse_clear();
        check_eq("t8_clr_errs", 512'({err_frame, err_addr, err_abort}), 512'(0));
        check_eq("t8_clr_count", 512'(load_count), 512'(0));
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        clear_status = 1'b1;
        send_word(32'd3, 1'b1);
        clear_status  = 1'b0;
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast  = 1'b0;
        check_eq("t8_clear_precedence", 512'(err_frame), 512'(0));

        // Asynchronous reset in the middle of a frame
        fill(32'd12, 32'hD000_0000);
        send_frame(16, 1'b0);
        run_post(first_hi, n_hi, n_nr);
        check_eq("t9_pre_count", 512'(load_count), 512'(1));
        fill(32'd13, 32'hE000_0000);
        for (int i = 0; i < 5; i++) begin
            send_word(fr[i], 1'b0);
        end
        aresetn = 1'b0;
        #1;
        check_eq("t9_vp_set", vp_set, 512'(0));
        check_eq("t9_outs", 512'({setvec, S_AXIS_tready, busy}), 512'(0));
        check_eq("t9_count", 512'(load_count), 512'(0));
        S_AXIS_tvalid = 1'b0;
        step();
        aresetn = 1'b1;
        step();
        fill(32'd14, 32'hF000_0000);
        send_frame(16, 1'b0);
        run_post(first_hi, n_hi, n_nr);
        check_eq("t9_restart_strobe", 512'(n_hi), 512'(4));
        exp_vp = pack_fr();
        check_eq("t9_restart_vp", vp_set, exp_vp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
